// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (0)
// and load/store (1), with grant hold for the whole access and an ack timeout.

module mem_port_mux2 #(
  parameter int W = 1
) (
  input  logic         s,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = s ? b : a;
endmodule

// Handshake: a requester raises req with stable addr/we/wdata and holds it
// until its done pulse; done (with err on timeout) ends the access, and a req
// still high in the done cycle is arbitrated as a fresh request.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              we0,
  input  logic              we1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              sel,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              dbg_state,
  output logic              dbg_prio
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [0:0]       state;
  logic             prio;
  logic [CNT_W-1:0] cnt;
  logic             win;
  logic             we_mux;
  logic             timeout_hit;

  // A lone requester wins outright; on contention the pointer decides.
  assign win         = (req0 & req1) ? prio : req1;
  assign timeout_hit = (cnt == CNT_LAST);

  mem_port_mux2 #(.W(ADDR_W)) u_addr_mux (
    .s(sel), .a(addr0), .b(addr1), .y(mem_addr)
  );

  mem_port_mux2 #(.W(1)) u_we_mux (
    .s(sel), .a(we0), .b(we1), .y(we_mux)
  );

  mem_port_mux2 #(.W(DATA_W)) u_wdata_mux (
    .s(sel), .a(wdata0), .b(wdata1), .y(mem_wdata)
  );

  assign mem_we    = mem_en & we_mux;
  assign dbg_state = state;
  assign dbg_prio  = prio;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      prio   <= 1'b0;
      cnt    <= '0;
      sel    <= 1'b0;
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      mem_en <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      err    <= 1'b0;
      rdata  <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            state  <= ACCESS;
            sel    <= win;
            gnt0   <= ~win;
            gnt1   <= win;
            mem_en <= 1'b1;
            cnt    <= '0;
          end
        end
        ACCESS: begin
          // An ack on the last allowed cycle still counts as a clean completion.
          if (mem_ack || timeout_hit) begin
            state  <= IDLE;
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            mem_en <= 1'b0;
            prio   <= ~sel;
            done0  <= ~sel;
            done1  <= sel;
            err    <= ~mem_ack;
            if (mem_ack && !we_mux) begin
              rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
